// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: holds the PC, issues one outstanding imem request
// at a time and presents {pc, instr, fault} to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  typedef enum logic [2:0] {REQ, WAIT, DRAIN, HOLD, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        valid_next, fault_next;
  logic [31:0] out_pc_next, instr_next;
  logic        misaligned;

  assign misaligned     = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state == REQ) && !redirect_valid && !rst && !misaligned;
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= 32'h0;
      if_fault <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      if_valid <= valid_next;
      if_pc    <= out_pc_next;
      if_instr <= instr_next;
      if_fault <= fault_next;
    end
  end

  // A redirect overrides everything; a squashed in-flight response must still be drained.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    valid_next  = if_valid;
    out_pc_next = if_pc;
    instr_next  = if_instr;
    fault_next  = if_fault;
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      fault_next = 1'b0;
      case (state)
        WAIT, DRAIN: state_next = imem_resp_valid ? REQ : DRAIN;
        default:     state_next = REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (misaligned) begin
            valid_next  = 1'b1;
            fault_next  = 1'b1;
            out_pc_next = pc;
            instr_next  = 32'h0;
            state_next  = HOLD;
          end else if (imem_req_ready) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            valid_next  = 1'b1;
            fault_next  = imem_resp_err;
            out_pc_next = pc;
            instr_next  = imem_resp_err ? 32'h0 : imem_resp_data;
            pc_next     = pc + 32'd4;
            state_next  = HOLD;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) state_next = REQ;
        end
        HOLD: begin
          if (if_ready) begin
            valid_next = 1'b0;
            state_next = if_fault ? HALT : REQ;
          end
        end
        HALT: state_next = HALT;
        default: state_next = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_fault;
  logic [31:0] if_pc, if_instr;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus knobs
  int          ready_pct, rqr_pct, err_pct, redir_pct, fix_lat;
  logic        force_redir, force_err, rst_cmd, rand_rst;
  logic [31:0] force_pc;

  // Memory environment
  logic        mem_busy, mem_err;
  int          mem_lat;
  logic [31:0] mem_addr;
  logic        accepted;

  // Reference model: fetch modelled as pending-request / presented-instruction flags
  logic [31:0] m_pc, m_if_pc, m_instr;
  logic        m_busy, m_squash, m_have, m_halt, m_fault, m_req;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_if_pc = RST_PC; m_instr = 32'h0;
    m_busy = 0; m_squash = 0; m_have = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic model_present(input logic err, input logic [31:0] data);
    m_have  = 1'b1;
    m_if_pc = m_pc;
    m_fault = err;
    m_instr = err ? 32'h0 : data;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      m_pc = redirect_pc; m_have = 0; m_fault = 0; m_halt = 0;
      if (m_busy && !imem_resp_valid) m_squash = 1'b1;
      else begin m_busy = 0; m_squash = 0; end
    end else if (m_busy) begin
      if (imem_resp_valid) begin
        m_busy = 1'b0;
        if (m_squash) m_squash = 1'b0;
        else begin
          model_present(imem_resp_err, imem_resp_data);
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_have) begin
      if (if_ready) begin
        m_have = 1'b0;
        if (m_fault) m_halt = 1'b1;
      end
    end else if (!m_halt) begin
      if (m_pc[1:0] != 2'b00) model_present(1'b1, 32'h0);
      else if (m_req && imem_req_ready) m_busy = 1'b1;
    end
  endtask

  task automatic apply_stimulus();
    rst = rst_cmd || (rand_rst && $urandom_range(0, 499) == 0);
    if (rst) model_reset();
    redirect_valid = force_redir || ($urandom_range(0, 99) < redir_pct);
    if (force_redir) redirect_pc = force_pc;
    else begin
      case ($urandom_range(0, 9))
        0:       redirect_pc = {$urandom_range(0, 1023), 2'b10};
        1:       redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = {20'h0, $urandom_range(0, 1023), 2'b00};
      endcase
    end
    force_redir     = 1'b0;
    if_ready        = ($urandom_range(0, 99) < ready_pct);
    imem_req_ready  = ($urandom_range(0, 99) < rqr_pct);
    imem_resp_valid = mem_busy && (mem_lat == 0);
    imem_resp_data  = mem_word(mem_addr);
    imem_resp_err   = mem_err;
  endtask

  task automatic check_output();
    m_req = !rst && !m_busy && !m_have && !m_halt && !redirect_valid && (m_pc[1:0] == 2'b00);
    chk("req_valid", {31'h0, imem_req_valid}, {31'h0, m_req});
    if (m_req) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", {31'h0, if_valid}, {31'h0, m_have});
    chk("if_fault", {31'h0, if_fault}, {31'h0, m_fault});
    chk("if_pc", if_pc, m_if_pc);
    chk("if_instr", if_instr, m_instr);
    accepted = imem_req_valid && imem_req_ready;
  endtask

  task automatic mem_step();
    if (imem_resp_valid) mem_busy = 1'b0;
    else if (mem_busy && mem_lat > 0) mem_lat--;
    if (accepted) begin
      mem_busy  = 1'b1;
      mem_addr  = imem_req_addr;
      mem_lat   = ((fix_lat != 0) ? fix_lat : $urandom_range(1, 3)) - 1;
      mem_err   = force_err || ($urandom_range(0, 99) < err_pct);
      force_err = 1'b0;
    end
  endtask

  // One clock: advance model and memory at the edge, then drive and compare mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    mem_step();
    @(negedge clk);
    apply_stimulus();
    #1;
    check_output();
  endtask

  initial begin
    ready_pct = 100; rqr_pct = 100; err_pct = 0; redir_pct = 0; fix_lat = 1;
    force_redir = 0; force_err = 0; force_pc = 0; rst_cmd = 1; rand_rst = 0;
    mem_busy = 0; mem_err = 0; mem_lat = 0; mem_addr = 0; accepted = 0; m_req = 0;
    rst = 1; redirect_valid = 0; redirect_pc = 0; if_ready = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; imem_resp_err = 0;
    model_reset();

    // Reset values and first fetch with 1-cycle memory
    tick(); tick();
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h100);
    chk("rst_if_instr", if_instr, 32'h0);
    rst_cmd = 0;
    tick();
    chk("c0_req_addr", imem_req_addr, 32'h100);
    tick(); tick();
    chk("c2_if_valid", {31'h0, if_valid}, 32'h1);
    chk("c2_if_pc", if_pc, 32'h100);
    chk("c2_if_instr", if_instr, 32'h0050_0093);
    tick();
    chk("c3_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("c3_req_addr", imem_req_addr, 32'h104);

    // Decode backpressure for 5 cycles
    ready_pct = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_if_pc", if_pc, 32'h104);
      chk("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
      if (i == 4) ready_pct = 100;
      tick();
    end
    tick();
    chk("after_stall_req", imem_req_addr, 32'h108);

    // Redirect while waiting; late response must be discarded
    fix_lat = 3; force_redir = 1; force_pc = 32'h200;
    tick(); tick(); tick();
    chk("drain_if_valid", {31'h0, if_valid}, 32'h0);
    fix_lat = 1;
    tick();
    chk("redir_req_addr", imem_req_addr, 32'h200);

    // Misaligned redirect faults, halts, and a new redirect restarts fetch
    force_redir = 1; force_pc = 32'h202;
    tick(); tick();
    chk("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("mis_if_fault", {31'h0, if_fault}, 32'h1);
    chk("mis_if_pc", if_pc, 32'h202);
    chk("mis_if_instr", if_instr, 32'h0);
    tick(); tick();
    chk("halt_no_req", {31'h0, imem_req_valid}, 32'h0);
    force_redir = 1; force_pc = 32'h300;
    tick(); tick();
    chk("halt_exit_req", imem_req_addr, 32'h300);

    // PC wrap and access error
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    tick(); tick();
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(); tick(); tick();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    force_err = 1;
    tick(); tick();
    chk("err_if_fault", {31'h0, if_fault}, 32'h1);
    chk("err_if_instr", if_instr, 32'h0);
    tick(); tick();
    chk("err_halt_no_req", {31'h0, imem_req_valid}, 32'h0);
    force_redir = 1; force_pc = 32'h100;
    tick(); tick();

    // Reset mid-WAIT with the stale response arriving after release
    fix_lat = 4;
    tick();
    rst_cmd = 1;
    tick();
    chk("midrst_if_pc", if_pc, 32'h100);
    tick();
    rst_cmd = 0; rqr_pct = 0;
    tick();
    chk("postrst_req_addr", imem_req_addr, 32'h100);
    rqr_pct = 100; fix_lat = 1;
    tick();
    chk("stale_ignored", {31'h0, if_valid}, 32'h0);
    tick(); tick();
    chk("postrst_if_instr", if_instr, 32'h0050_0093);

    // Randomized traffic
    fix_lat = 0; ready_pct = 70; rqr_pct = 70; err_pct = 5; redir_pct = 5; rand_rst = 1;
    for (int i = 0; i < 4000; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
